// File: rtl/snn_lif_layer_tdm.sv
// Time-multiplexed leaky integrate-and-fire layer: one neuron updated per cycle per timestep.
// Optional leak is built only when SNN_LIF_LEAK_EN is defined; otherwise pure integrate-and-fire.
module snn_lif_layer_tdm #(
  parameter int NUM_INPUTS  = 4,
  parameter int NUM_NEURONS = 4,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE    = 16,
  parameter int THRESH      = 15,
  parameter int RESET       = 0,
  parameter int REFRAC      = 5,
  parameter int LEAK        = 1,
  localparam int NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
  localparam int IW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_INPUTS-1:0]         spike_in,
  input  logic                          wr_en,
  input  logic [NW-1:0]                 wr_neuron,
  input  logic [IW-1:0]                 wr_input,
  input  logic signed [WEIGHT_SIZE-1:0] wr_data,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_NEURONS-1:0]        spike_out
);

  localparam int SW  = WEIGHT_SIZE + $clog2(NUM_INPUTS) + 1;
  localparam int RW  = ((POT_SIZE > SW) ? POT_SIZE : SW) + 2;
  localparam int RFW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  localparam logic signed [RW-1:0] POT_MAX_W = $signed({{(RW-POT_SIZE+1){1'b0}}, {(POT_SIZE-1){1'b1}}});
  localparam logic signed [RW-1:0] POT_MIN_W = $signed({{(RW-POT_SIZE+1){1'b1}}, {(POT_SIZE-1){1'b0}}});
  localparam logic signed [RW-1:0] THRESH_W  = RW'(THRESH);
  localparam logic signed [RW-1:0] RESET_W   = RW'(RESET);
  localparam logic signed [POT_SIZE-1:0] RESET_P = POT_SIZE'(RESET);
  localparam logic [RFW-1:0] REFRAC_R = RFW'(REFRAC);
  localparam logic [NW-1:0]  LAST_IDX = NW'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_t;

  state_t                      state_r, state_s;
  logic [NW-1:0]               idx_r;
  logic [NUM_INPUTS-1:0]       spk_lat_r;
  logic                        busy_r, done_r;
  logic [NUM_NEURONS-1:0]      spike_out_r, next_spike_r, spikes_s;
  logic signed [WEIGHT_SIZE-1:0] w_r [NUM_NEURONS][NUM_INPUTS];
  logic signed [POT_SIZE-1:0]  pot_r [NUM_NEURONS];
  logic [RFW-1:0]              refrac_r [NUM_NEURONS];
  logic signed [SW-1:0]        sum_s;
  logic signed [RW-1:0]        pot_ext_s, leaked_s, result_s, sat_s;
  logic                        in_refrac_s, fire_s, spike_bit_s, wr_ok_s;

  assign busy      = busy_r;
  assign done      = done_r;
  assign spike_out = spike_out_r;

  // Synaptic sum of the current neuron over latched active inputs
  always_comb begin
    sum_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spk_lat_r[i]) sum_s = sum_s + SW'(w_r[idx_r][i]);
      else              sum_s = sum_s;
    end
  end

  // Leak, integrate, saturate and threshold for the neuron under update
  always_comb begin
    pot_ext_s = RW'(pot_r[idx_r]);
    leaked_s  = pot_ext_s;
`ifdef SNN_LIF_LEAK_EN
    // Leak never overshoots RESET, whichever side the potential sits on
    if (pot_ext_s > RESET_W) begin
      if (pot_ext_s - RESET_W > RW'(LEAK)) leaked_s = pot_ext_s - RW'(LEAK);
      else                                 leaked_s = RESET_W;
    end else if (pot_ext_s < RESET_W) begin
      if (RESET_W - pot_ext_s > RW'(LEAK)) leaked_s = pot_ext_s + RW'(LEAK);
      else                                 leaked_s = RESET_W;
    end else begin
      leaked_s = pot_ext_s;
    end
`else
    leaked_s = pot_ext_s;
`endif
    result_s = leaked_s + RW'(sum_s);
    if (result_s > POT_MAX_W)      sat_s = POT_MAX_W;
    else if (result_s < POT_MIN_W) sat_s = POT_MIN_W;
    else                           sat_s = result_s;
    in_refrac_s = (refrac_r[idx_r] != '0);
    fire_s      = (sat_s >= THRESH_W);
    spike_bit_s = !in_refrac_s && fire_s;
    spikes_s         = next_spike_r;
    spikes_s[idx_r]  = spike_bit_s;
    wr_ok_s = (state_r == S_IDLE) && wr_en &&
              (int'(wr_neuron) < NUM_NEURONS) && (int'(wr_input) < NUM_INPUTS);
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) state_s = S_UPDATE;
        else       state_s = S_IDLE;
      end
      S_UPDATE: begin
        if (idx_r == LAST_IDX) state_s = S_DONE;
        else                   state_s = S_UPDATE;
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Control registers; spike_out is published together with the last neuron's result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      idx_r        <= '0;
      spk_lat_r    <= '0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      spike_out_r  <= '0;
      next_spike_r <= '0;
    end else begin
      state_r <= state_s;
      done_r  <= 1'b0;
      if (state_r == S_IDLE && start) begin
        spk_lat_r <= spike_in;
        idx_r     <= '0;
        busy_r    <= 1'b1;
      end else if (state_r == S_UPDATE) begin
        next_spike_r[idx_r] <= spike_bit_s;
        if (idx_r == LAST_IDX) begin
          spike_out_r <= spikes_s;
          busy_r      <= 1'b0;
          done_r      <= 1'b1;
        end else begin
          idx_r <= idx_r + NW'(1);
        end
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  // Weight memory write port, open only in IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_NEURONS; n++)
        for (int i = 0; i < NUM_INPUTS; i++)
          w_r[n][i] <= '0;
    end else if (wr_ok_s) begin
      w_r[wr_neuron][wr_input] <= wr_data;
    end else begin
      w_r <= w_r;
    end
  end

  // Membrane potential and refractory counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        pot_r[n]    <= RESET_P;
        refrac_r[n] <= '0;
      end
    end else if (state_r == S_UPDATE) begin
      if (in_refrac_s) begin
        refrac_r[idx_r] <= refrac_r[idx_r] - RFW'(1);
        pot_r[idx_r]    <= RESET_P;
      end else if (fire_s) begin
        refrac_r[idx_r] <= REFRAC_R;
        pot_r[idx_r]    <= RESET_P;
      end else begin
        pot_r[idx_r]    <= sat_s[POT_SIZE-1:0];
      end
    end else begin
      pot_r <= pot_r;
    end
  end

endmodule
